// File: rtl/plab4_net_router_input_domain_queue_tp.sv
// Timing-channel-protected router input queue.
// Two per-domain FIFOs feed the terminal control under a fixed,
// traffic-independent time-division slot schedule. Only the domain that
// owns the current slot can issue. The other FIFO is never popped and never
// drives the outputs.
// Optional build macro: PLAB4_NET_INPUT_QUEUE_TP_GUARD_CYCLE_EN blanks
// out_val in the last cycle of every slot.

// Per-domain circular FIFO. The pointers wrap naturally because the depth is
// a power of two.
module plab4_net_router_input_domain_queue_tp_fifo #(
  parameter int p_msg_nbits   = 44,
  parameter int p_num_entries = 2
)(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enq,
  input  logic                   deq,
  input  logic [p_msg_nbits-1:0] enq_msg,
  output logic                   full,
  output logic                   empty,
  output logic [p_msg_nbits-1:0] head
);

  localparam int PTR_W = $clog2(p_num_entries);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(p_num_entries);

  logic [p_num_entries-1:0][p_msg_nbits-1:0] mem;
  logic [PTR_W-1:0]                          wr_ptr;
  logic [PTR_W-1:0]                          rd_ptr;
  logic [CNT_W-1:0]                          count;
  logic                                      do_enq;
  logic                                      do_deq;

  assign full   = (count == FULL_CNT);
  assign empty  = (count == '0);
  assign head   = mem[rd_ptr];
  // A full FIFO refuses a push even while it is popping in the same cycle.
  assign do_enq = enq && !full;
  assign do_deq = deq && !empty;

  // Storage write. It is cleared on reset so that the reset-state head is deterministic.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem <= '0;
    end else if (do_enq) begin
      mem[wr_ptr] <= enq_msg;
    end
  end

  // Pointer and occupancy update. A simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_enq) wr_ptr <= wr_ptr + 1'b1;
      if (do_deq) rd_ptr <= rd_ptr + 1'b1;
      case ({do_enq, do_deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

module plab4_net_router_input_domain_queue_tp #(
  parameter int p_msg_nbits   = 44,
  parameter int p_dest_lsb    = 33,
  parameter int p_dest_nbits  = 3,
  parameter int p_num_entries = 2,
  parameter int p_slot_cycles = 4
)(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_val,
  output logic                    in_rdy,
  input  logic [p_msg_nbits-1:0]  in_msg,
  input  logic                    in_domain,
  output logic                    out_val,
  input  logic                    out_rdy,
  output logic [p_msg_nbits-1:0]  out_msg,
  output logic [p_dest_nbits-1:0] dest,
  output logic                    domain0,
  output logic                    domain1
);

  localparam int NUM_DOM = 2;
  localparam int SLOT_W  = (p_slot_cycles > 1) ? $clog2(p_slot_cycles) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(p_slot_cycles - 1);

  logic [SLOT_W-1:0]                      slot_cnt;
  logic                                   active;
  logic                                   slot_last;
  logic                                   guard;
  logic [NUM_DOM-1:0]                     enq;
  logic [NUM_DOM-1:0]                     deq;
  logic [NUM_DOM-1:0]                     full;
  logic [NUM_DOM-1:0]                     empty;
  logic [NUM_DOM-1:0][p_msg_nbits-1:0]    head;

  assign slot_last = (slot_cnt == SLOT_LAST);

`ifdef PLAB4_NET_INPUT_QUEUE_TP_GUARD_CYCLE_EN
  // Keep the slot edge quiet so that no launch straddles a domain switch.
  assign guard = slot_last;
`else
  assign guard = 1'b0;
`endif

  // Slot scheduler. It free-runs so that the schedule carries no information about the traffic.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_cnt <= '0;
      active   <= 1'b0;
    end else if (slot_last) begin
      slot_cnt <= '0;
      active   <= !active;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  assign domain0 = !active;
  assign domain1 = active;

  // in_rdy looks only at the addressed domain's registered fullness. This
  // keeps one domain's backpressure invisible to the other.
  assign in_rdy  = !full[in_domain];
  assign out_val = !empty[active] && !guard;
  assign out_msg = head[active];
  assign dest    = out_msg[p_dest_lsb +: p_dest_nbits];

  for (genvar d = 0; d < NUM_DOM; d++) begin : g_dom
    assign enq[d] = in_val && in_rdy && (in_domain == 1'(d));
    assign deq[d] = out_val && out_rdy && (active == 1'(d));

    plab4_net_router_input_domain_queue_tp_fifo #(
      .p_msg_nbits   (p_msg_nbits),
      .p_num_entries (p_num_entries)
    ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .enq     (enq[d]),
      .deq     (deq[d]),
      .enq_msg (in_msg),
      .full    (full[d]),
      .empty   (empty[d]),
      .head    (head[d])
    );
  end

endmodule

// File: tb/tb_plab4_net_router_input_domain_queue_tp.sv
// Bench for the timing-protected input domain queue: transaction-level
// queue model + free-running slot model, scoreboard popped on DUT issue.
module tb_plab4_net_router_input_domain_queue_tp;

  localparam int W  = 44;
  localparam int DL = 33;
  localparam int DN = 3;
  localparam int NE = 2;
  localparam int SC = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_val = 1'b0;
  logic          in_rdy;
  logic [W-1:0]  in_msg = '0;
  logic          in_domain = 1'b0;
  logic          out_val;
  logic          out_rdy = 1'b0;
  logic [W-1:0]  out_msg;
  logic [DN-1:0] dest;
  logic          domain0;
  logic          domain1;

  int n_cmp = 0;
  int n_err = 0;
  int n_pop = 0;
  bit chk_en = 0;

  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  int           m_cnt = 0;
  logic         m_act = 1'b0;
  bit           m_pop, m_push;
  logic [W-1:0] hd_e;
  logic [W-1:0] t_msg;

  plab4_net_router_input_domain_queue_tp #(
    .p_msg_nbits(W), .p_dest_lsb(DL), .p_dest_nbits(DN),
    .p_num_entries(NE), .p_slot_cycles(SC)
  ) dut (
    .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy),
    .in_msg(in_msg), .in_domain(in_domain), .out_val(out_val),
    .out_rdy(out_rdy), .out_msg(out_msg), .dest(dest),
    .domain0(domain0), .domain1(domain1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic int qsize(input logic d);
    return d ? q1.size() : q0.size();
  endfunction

  function automatic logic [W-1:0] qfront(input logic d);
    if (d) return (q1.size() != 0) ? q1[0] : '0;
    return (q0.size() != 0) ? q0[0] : '0;
  endfunction

  function automatic bit m_guard();
`ifdef PLAB4_NET_INPUT_QUEUE_TP_GUARD_CYCLE_EN
    return m_cnt == SC - 1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_oval();
    return qsize(m_act) != 0 && !m_guard();
  endfunction

  function automatic bit m_irdy();
    return qsize(in_domain) < NE;
  endfunction

  // Reference model: slot counter and per-domain expected-message queues.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q0.delete();
      q1.delete();
      m_cnt = 0;
      m_act = 1'b0;
    end else begin
      m_pop  = m_oval() && out_rdy;
      m_push = in_val && m_irdy();
      if (m_pop) begin
        if (m_act) void'(q1.pop_front());
        else       void'(q0.pop_front());
      end
      if (m_push) begin
        if (in_domain) q1.push_back(in_msg);
        else           q0.push_back(in_msg);
      end
      if (m_cnt == SC - 1) begin
        m_cnt = 0;
        m_act = !m_act;
      end else begin
        m_cnt++;
      end
    end
  end

  // Mid-cycle checks against the model; issued messages are scoreboard-compared.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("domain0", 64'(domain0), 64'(m_act == 1'b0));
      chk("domain1", 64'(domain1), 64'(m_act == 1'b1));
      chk("in_rdy", 64'(in_rdy), 64'(m_irdy()));
      chk("out_val", 64'(out_val), 64'(m_oval()));
      if (out_val && m_oval()) begin
        hd_e = qfront(m_act);
        chk("out_msg", 64'(out_msg), 64'(hd_e));
        chk("dest", 64'(dest), 64'(hd_e[DL +: DN]));
        if (out_rdy) n_pop++;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mk_msg(input logic [DN-1:0] d, output logic [W-1:0] m);
    m = W'({$urandom, $urandom});
    m[DL +: DN] = d;
  endtask

  task automatic send(input logic dom, input logic [DN-1:0] d);
    mk_msg(d, t_msg);
    in_val    = 1'b1;
    in_domain = dom;
    in_msg    = t_msg;
    cyc();
    in_val    = 1'b0;
  endtask

  task automatic wait_slot(input logic d);
    for (int i = 0; i < 4 * SC && !(m_cnt == 0 && m_act == d); i++) cyc();
    chk("wait_slot", 64'(m_cnt == 0 && m_act == d), 64'd1);
  endtask

  initial begin
    #2 reset = 1'b0;
    chk_en = 1;
    #1;
    chk("rst_oval", 64'(out_val), 64'd0);
    chk("rst_dom0", 64'(domain0), 64'd1);
    chk("rst_irdy", 64'(in_rdy), 64'd1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Idle: domain alternation is checked every cycle by the monitor.
    repeat (9) cyc();

    // Single domain-0 message: visible 1 cycle later, popped, then empty.
    wait_slot(1'b0);
    out_rdy = 1'b1;
    send(1'b0, 3'h5);
    #3;
    chk("lat_val", 64'(out_val), 64'd1);
    chk("lat_dest", 64'(dest), 64'h5);
    cyc();
    #3;
    chk("lat_empty", 64'(out_val), 64'd0);

    // Fill domain-1 FIFO with no drain; domain 0 must be unaffected.
    out_rdy = 1'b0;
    send(1'b1, 3'h1);
    send(1'b1, 3'h2);
    in_domain = 1'b1;
    #1 chk("full1_rdy", 64'(in_rdy), 64'd0);
    in_domain = 1'b0;
    #1 chk("full1_rdy0", 64'(in_rdy), 64'd1);
    wait_slot(1'b0);
    out_rdy = 1'b1;
    send(1'b0, 3'h3);
    #3;
    chk("iso_val", 64'(out_val), 64'd1);
    chk("iso_dest", 64'(dest), 64'h3);

    // A domain-1 message enqueued in the domain-0 slot waits for its own slot.
    wait_slot(1'b0);
    send(1'b1, 3'h6);
    for (int i = 1; i < SC; i++) begin
      #3 chk("wait_d1", 64'(out_val), 64'd0);
      cyc();
    end
    #3;
    chk("d1_val", 64'(out_val), 64'd1);
    chk("d1_dest", 64'(dest), 64'h6);

    // Preload one entry, then stream with simultaneous push and pop.
    out_rdy = 1'b0;
    wait_slot(1'b1);
    send(1'b0, 3'h0);
    wait_slot(1'b0);
    out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) send(1'b0, 3'(i + 1));
    repeat (2 * SC) cyc();

    // Random mixed traffic.
    for (int i = 0; i < 400; i++) begin
      in_val    = $urandom_range(0, 1);
      in_domain = $urandom_range(0, 1);
      out_rdy   = ($urandom_range(0, 3) != 0);
      mk_msg(3'($urandom_range(0, 7)), t_msg);
      in_msg    = t_msg;
      cyc();
    end
    in_val = 1'b0;

    // Reset mid-slot with both FIFOs loaded.
    out_rdy = 1'b0;
    send(1'b0, 3'h2);
    send(1'b1, 3'h4);
    wait_slot(1'b1);
    cyc();
    reset = 1'b0;
    #1;
    chk("mid_rst_oval", 64'(out_val), 64'd0);
    chk("mid_rst_dom0", 64'(domain0), 64'd1);
    chk("mid_rst_irdy", 64'(in_rdy), 64'd1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    out_rdy = 1'b1;
    repeat (2 * SC + 1) cyc();

    chk("pops_seen", 64'(n_pop > 10), 64'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/plab4_net_router_input_domain_queue_tp.md
Name: plab4_net_router_input_domain_queue_tp

Overview:
- Timing-channel-protected input stage directly upstream of the router input terminal control.
- Buffers injected messages in per-domain FIFOs and runs a fixed time-division slot schedule.
- Presents the active domain's head message (out_val/out_msg/dest) with one-hot domain0/domain1 to the terminal control.
- Domain-0 timing and flow control are independent of domain-1 occupancy and traffic, and vice versa.

Parameters:
- p_msg_nbits, 44, message width.
- p_dest_lsb, 33, bit position of the dest field in the message.
- p_dest_nbits, 3, dest field width (log2 of number of routers).
- p_num_entries, 2, FIFO depth per domain; power of two, >=2.
- p_slot_cycles, 4, cycles per domain slot; >=2.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- in_val  in  1  injection valid.
- in_rdy  out  1  injection ready for the domain selected by in_domain.
- in_msg  in  p_msg_nbits  injected message.
- in_domain  in  1  security domain of in_msg.
- out_val  out  1  active domain's head message valid.
- out_rdy  in  1  downstream accept.
- out_msg  out  p_msg_nbits  active domain's head message.
- dest  out  p_dest_nbits  out_msg[p_dest_lsb +: p_dest_nbits].
- domain0  out  1  slot owned by domain 0.
- domain1  out  1  slot owned by domain 1.

Behaviour:
- Reset (reset==0, async):
  - Both FIFOs empty; slot counter 0; active domain 0.
  - Outputs: out_val=0, domain0=1, domain1=0, in_rdy=1, out_msg/dest = contents of FIFO0 entry 0 (don't-care).
- Enqueue:
  - Occurs when in_val && in_rdy; writes FIFO[in_domain].
  - in_rdy = !full[in_domain], purely from registered state; no bypass.
  - A full FIFO refuses enqueue even while dequeuing that cycle.
- Dequeue:
  - out_val = !empty[active] && !guard; out_msg = head of FIFO[active].
  - Pop occurs on out_val && out_rdy.
  - The inactive FIFO is never popped and never drives the outputs.
- Latency: a message enqueued at edge N is visible at out_val from cycle N+1 if its domain is active (1-cycle minimum, no bypass).
- Simultaneous events:
  - Enqueue and dequeue on the same FIFO in one cycle: both take effect; count unchanged.
  - Enqueue on one FIFO and dequeue on the other: independent.
- Pointers: wrap modulo p_num_entries; count width clog2(p_num_entries)+1.
  - full: count == p_num_entries.
  - empty: count == 0.
- Slot scheduler:
  - Counter runs 0..p_slot_cycles-1.
  - On the edge where the counter is p_slot_cycles-1: counter -> 0 and active toggles.
  - domain0 = (active==0); domain1 = (active==1); always one-hot.
  - Advances every cycle regardless of traffic, so the schedule is data-independent.
- Slot boundary: a pop in the last cycle of a slot completes; the next cycle belongs to the other domain.
- Reset mid-operation: immediately returns to the reset state; buffered messages are discarded.
- guard = 0 unless GUARD_CYCLE_EN is defined.

Optional Feature:
- Macro: PLAB4_NET_INPUT_QUEUE_TP_GUARD_CYCLE_EN.
- Defined: guard = (counter == p_slot_cycles-1).
  - out_val is forced 0 in the last cycle of each slot so no message launches at a slot edge.
  - in_rdy is unaffected.
  - Requires p_slot_cycles >= 2.
- Undefined: guard is constant 0; every slot cycle may issue.

Test Plan:
- Reset then idle 8 cycles:
  - out_val=0, in_rdy=1 throughout.
  - domain0=1 for cycles 0-3, domain1=1 for cycles 4-7, domain0=1 at cycle 8.
- Enqueue msg dest=3'h5, domain 0, at cycle 0 with out_rdy=1:
  - out_val=1 and dest=5 at cycle 1; popped at cycle 1; out_val=0 at cycle 2.
- Fill domain-1 FIFO (2 msgs, out_rdy=0):
  - in_rdy=0 for in_domain=1, in_rdy=1 for in_domain=0.
  - A domain-0 message issues in the domain-0 slot with the same latency as when FIFO1 is empty.
- Enqueue domain-1 msg during the domain-0 slot:
  - out_val stays 0 until the first domain-1 slot cycle (cycle 4), then out_val=1 and out_msg equals that msg.
- Same-cycle enqueue and dequeue on domain-0 FIFO holding 1 entry:
  - Count stays 1; FIFO order preserved over 4 messages.
- With the guard macro defined and FIFO0 holding 2 msgs, out_rdy=1:
  - Pops occur at cycles 0 and 1; cycle 3 shows out_val=0 even if FIFO0 is refilled.
- Assert reset (reset=0) mid-slot with both FIFOs non-empty:
  - out_val=0 immediately; domain0=1; counter 0; both FIFOs empty after release.
